// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration word and its serial loader.
// clb11 and any config-store block decode fields using these bit positions.
package clb_cfg_pkg;

  localparam int         CFG_W     = 38;
  localparam logic [7:0] SYNC_PAT  = 8'b1111_0010;
  localparam int         STOP_BITS = 2;

  // Field positions inside the 38-bit configuration word
  localparam int MUX2_LSB      = 36;
  localparam int MUX3_LSB      = 34;
  localparam int MUX4_LSB      = 32;
  localparam int MUX5_LSB      = 30;
  localparam int MUX6_LSB      = 28;
  localparam int MEM_LSB       = 12;
  localparam int MEM_W         = 16;
  localparam int COMBO_LSB     = 10;
  localparam int O2M1_0_BIT    = 9;
  localparam int O2M2_0_BIT    = 8;
  localparam int O2M3_0_BIT    = 7;
  localparam int O2M1_1_BIT    = 6;
  localparam int O2M2_1_BIT    = 5;
  localparam int O2M3_1_BIT    = 4;
  localparam int DQMUX1_BIT    = 3;
  localparam int DQMUX2_BIT    = 2;
  localparam int FLOPLATCH_BIT = 1;
  localparam int INITQ_BIT     = 0;

  typedef enum logic [2:0] {
    ST_HUNT, ST_LEN, ST_START, ST_DATA, ST_STOP1, ST_STOP2, ST_DONE, ST_ERR
  } cfg_state_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// Enable-gated serial-in/parallel-out register, MSB first; clear wins over shift.
module cfg_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: sync hunt, 8-bit CLB count, then one
// start/38-bit/stop/stop frame per CLB turned into an addressed write.
module clb_cfg_loader #(
  parameter int NUM_CLB = 64,
  parameter int ADDR_W  = 6,
  parameter int CFG_W   = clb_cfg_pkg::CFG_W
) (
  input  logic              K,
  input  logic              RST_N,
  input  logic              DIN,
  input  logic              DVALID,
  output logic [CFG_W-1:0]  CFG_DATA,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic              CFG_WE,
  output logic              DONE,
  output logic              ERR
);
  import clb_cfg_pkg::*;

  localparam logic [8:0] MAX_N         = 9'(NUM_CLB);
  localparam logic [5:0] LAST_DATA_BIT = 6'(CFG_W - 1);

  cfg_state_t       state, state_n;
  logic [5:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       idx, idx_n;
  logic [6:0]       win_q;
  logic [7:0]       cnt_q;
  logic [CFG_W-1:0] word_q;
  logic             win_en, win_clr, cnt_en, word_en, wr;
  logic             match;
  logic [7:0]       n_next;

  // The window keeps only the last 7 bits; the bit being sampled completes it.
  cfg_shift_reg #(.W(7)) u_win (
    .clk(K), .rst_n(RST_N), .en(win_en), .clr(win_clr), .din(DIN), .q(win_q)
  );
  cfg_shift_reg #(.W(8)) u_cnt (
    .clk(K), .rst_n(RST_N), .en(cnt_en), .clr(1'b0), .din(DIN), .q(cnt_q)
  );
  cfg_shift_reg #(.W(CFG_W)) u_word (
    .clk(K), .rst_n(RST_N), .en(word_en), .clr(1'b0), .din(DIN), .q(word_q)
  );

  assign match  = ({win_q, DIN} == SYNC_PAT);
  assign n_next = {cnt_q[6:0], DIN};

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    idx_n     = idx;
    win_en    = 1'b0;
    win_clr   = 1'b0;
    cnt_en    = 1'b0;
    word_en   = 1'b0;
    wr        = 1'b0;
    if (DVALID) begin
      unique case (state)
        ST_HUNT: begin
          win_en = 1'b1;
          if (match) begin
            win_clr = 1'b1;
            state_n = ST_LEN;
          end
        end
        ST_LEN: begin
          cnt_en    = 1'b1;
          bit_cnt_n = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_cnt_n = 6'd0;
            if (n_next == 8'd0)               state_n = ST_DONE;
            else if ({1'b0, n_next} > MAX_N)  state_n = ST_ERR;
            else                              state_n = ST_START;
          end
        end
        ST_START: state_n = DIN ? ST_ERR : ST_DATA;
        ST_DATA: begin
          word_en   = 1'b1;
          bit_cnt_n = bit_cnt + 6'd1;
          if (bit_cnt == LAST_DATA_BIT) begin
            bit_cnt_n = 6'd0;
            state_n   = ST_STOP1;
          end
        end
        ST_STOP1: state_n = DIN ? ST_STOP2 : ST_ERR;
        ST_STOP2: begin
          if (!DIN) begin
            state_n = ST_ERR;
          end else begin
            wr      = 1'b1;
            idx_n   = idx + 8'd1;
            state_n = (idx_n == cnt_q) ? ST_DONE : ST_START;
          end
        end
        default: ; // DONE and ERR hold until reset
      endcase
    end
  end

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_HUNT;
      bit_cnt  <= '0;
      idx      <= '0;
      CFG_DATA <= '0;
      CFG_ADDR <= '0;
      CFG_WE   <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      idx     <= idx_n;
      CFG_WE  <= wr;
      if (wr) begin
        CFG_DATA <= word_q;
        CFG_ADDR <= idx[ADDR_W-1:0];
      end
    end
  end

  assign DONE = (state == ST_DONE);
  assign ERR  = (state == ST_ERR);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader: bit streams are parsed by a stream-level model that
// predicts writes and DONE/ERR after every sampled bit; a monitor checks writes.
module tb_clb_cfg_loader;

  localparam int         NUM_CLB = 64;
  localparam int         ADDR_W  = 6;
  localparam int         CFG_W   = 38;
  localparam int         EW      = ADDR_W + CFG_W;
  localparam logic [7:0] SYNC    = 8'b1111_0010;

  logic K = 1'b0, RST_N = 1'b0, DIN = 1'b0, DVALID = 1'b0;
  logic [CFG_W-1:0]  CFG_DATA;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic              CFG_WE, DONE, ERR;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;
  bit            stream[$];
  int            n_cmp = 0, n_bad = 0;

  clb_cfg_loader #(.NUM_CLB(NUM_CLB), .ADDR_W(ADDR_W), .CFG_W(CFG_W)) dut (
    .K(K), .RST_N(RST_N), .DIN(DIN), .DVALID(DVALID),
    .CFG_DATA(CFG_DATA), .CFG_ADDR(CFG_ADDR), .CFG_WE(CFG_WE),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 K = ~K;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Parses the first len stream bits; returns 0 in progress, 1 done, 2 error.
  function automatic int model_run(input int len, input bit push);
    logic [7:0]       w;
    logic [CFG_W-1:0] word;
    int               p, n;
    bit               locked;
    w = '0; p = 0; n = 0; locked = 0;
    while (p < len && !locked) begin
      w = {w[6:0], stream[p]};
      p++;
      if (w == SYNC) locked = 1;
    end
    if (!locked || p + 8 > len) return 0;
    for (int i = 0; i < 8; i++) begin
      n = n * 2 + int'(stream[p]);
      p++;
    end
    if (n == 0) return 1;
    if (n > NUM_CLB) return 2;
    for (int f = 0; f < n; f++) begin
      if (p >= len) return 0;
      if (stream[p]) return 2;
      p++;
      if (p + CFG_W > len) return 0;
      word = '0;
      for (int i = 0; i < CFG_W; i++) begin
        word = {word[CFG_W-2:0], stream[p]};
        p++;
      end
      for (int s = 0; s < 2; s++) begin
        if (p >= len) return 0;
        if (!stream[p]) return 2;
        p++;
      end
      if (push) exp_q.push_back({6'(f), word});
    end
    return 1;
  endfunction

  function automatic void put(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) stream.push_back(v[i]);
  endfunction

  function automatic void put_frame(input logic [CFG_W-1:0] word);
    put(64'd0, 1);
    put(64'(word), CFG_W);
    put(64'd3, 2);
  endfunction

  function automatic logic [CFG_W-1:0] rand_word();
    return CFG_W'({$urandom(), $urandom()});
  endfunction

  // Write monitor: every strobe must match the head of the expected queue.
  always @(posedge K) begin
    #1;
    if (CFG_WE) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h required no write", CFG_ADDR, CFG_DATA);
      end else begin
        last_exp = exp_q.pop_front();
        check("write", {CFG_ADDR, CFG_DATA}, 64'(last_exp));
      end
    end
  end

  task automatic do_reset();
    @(negedge K);
    #2;
    RST_N  = 1'b0;
    DVALID = 1'b0;
    #1;
    check("rst_we",   CFG_WE,   0);
    check("rst_data", CFG_DATA, 0);
    check("rst_addr", CFG_ADDR, 0);
    check("rst_done", DONE,     0);
    check("rst_err",  ERR,      0);
    exp_q.delete();
    last_exp = '0;
    #3;
    RST_N = 1'b1;
  endtask

  task automatic idle(input int cyc, input int st);
    for (int c = 0; c < cyc; c++) begin
      @(negedge K);
      DVALID = 1'b0;
      DIN    = 1'($urandom());
      @(posedge K);
      #1;
      check("gap_done", DONE, 64'(st == 1));
      check("gap_err",  ERR,  64'(st == 2));
    end
  endtask

  // gap: 0 none, 1 three idle cycles before every other bit, 2 random idles
  task automatic send(input int gap);
    int st;
    st = 0;
    for (int i = 0; i < stream.size(); i++) begin
      if (gap == 1 && i % 2 == 1) idle(3, st);
      else if (gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4), st);
      @(negedge K);
      DIN    = stream[i];
      DVALID = 1'b1;
      @(posedge K);
      #1;
      st = model_run(i + 1, 0);
      check("bit_done", DONE, 64'(st == 1));
      check("bit_err",  ERR,  64'(st == 2));
    end
    @(negedge K);
    DVALID = 1'b0;
  endtask

  task automatic run(input string tag, input int gap);
    int st;
    st = model_run(stream.size(), 1);
    send(gap);
    repeat (3) @(posedge K);
    #1;
    check({tag, "_pending"}, 64'(exp_q.size()), 0);
    check({tag, "_done"}, DONE, 64'(st == 1));
    check({tag, "_err"},  ERR,  64'(st == 2));
    check({tag, "_last"}, {CFG_ADDR, CFG_DATA}, 64'(last_exp));
  endtask

  task automatic rand_load(input int n, input int gap, input bit corrupt);
    int pos;
    stream.delete();
    put(64'($urandom_range(0, 15)), 4);
    put(64'(SYNC), 8);
    put(64'(n), 8);
    for (int f = 0; f < n; f++) put_frame(rand_word());
    if (corrupt) begin
      pos = $urandom_range(12, stream.size() - 1);
      stream[pos] = !stream[pos];
    end
    put(64'($urandom()), 10);
    run("rand", gap);
  endtask

  initial begin
    do_reset();

    // Two-CLB load with an 8-ones sync preamble
    stream.delete();
    put(64'hFF2, 12); put(64'h02, 8);
    put_frame(38'h28_0001_6000); put_frame(38'h3F_FFFF_FFFF);
    run("load2", 0);

    // Noise ahead of the sync pattern
    do_reset();
    stream.delete();
    put(64'b0101, 4); put(64'hFF2, 12); put(64'h02, 8);
    put_frame(38'h28_0001_6000); put_frame(38'h3F_FFFF_FFFF);
    run("noise", 0);

    // Zero count then trailing frame-like bits
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'h00, 8); put_frame(rand_word());
    run("zero", 0);

    // Count above NUM_CLB, then a valid stream that must be ignored
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'd65, 8);
    put(64'(SYNC), 8); put(64'h01, 8); put_frame(rand_word());
    run("over", 0);

    // Bad second stop bit on frame 0
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'h02, 8);
    put(64'd0, 1); put(64'(rand_word()), CFG_W); put(64'b10, 2);
    put_frame(rand_word());
    run("stop2", 0);

    // One-CLB load with DVALID gaps
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'h01, 8); put_frame(rand_word());
    run("gaps", 1);

    // Abort mid-data of frame 1, then a fresh load
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'h02, 8); put_frame(rand_word()); put_frame(rand_word());
    while (stream.size() > 8 + 8 + 42 + 1 + 20) void'(stream.pop_back());
    run("abort", 0);
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'h02, 8); put_frame(rand_word()); put_frame(rand_word());
    run("fresh", 0);

    // Maximum count: addresses 0..63
    do_reset();
    stream.delete();
    put(64'(SYNC), 8); put(64'(NUM_CLB), 8);
    for (int f = 0; f < NUM_CLB; f++) put_frame(rand_word());
    run("max", 0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      rand_load($urandom_range(1, 5), 2, ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
